// File: rtl/bubble_alu_seq.sv
// Purpose: handshaked execute unit with single-cycle ALU ops and iterative mul/div; `BUBBLE_ALU_SIGNED_MD_EN adds signed MUL/DIV.
// Latency: 1 cycle for single-cycle/illegal/div-by-zero results, WIDTH+1 cycles for multiply and divide.
// Backpressure: result is held in DONE until out_ready; in_ready only in IDLE, so no request is taken while a result is pending.
module bubble_alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero,
    output logic             illegal_op
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_MULU = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;

    state_t state, state_nxt;
    logic             accept, mul_op, div_op, go_exec, last_iter;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] hi, lo, mcand, hi_n, lo_n;
    logic             is_div_q, neg_q, neg_r;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             neg_q_in, neg_r_in;
    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_dbz, sc_ill;
    logic [WIDTH:0]   mul_add, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    assign accept    = in_valid & in_ready;
    assign last_iter = (cnt == SHW'(WIDTH-1));

`ifdef BUBBLE_ALU_SIGNED_MD_EN
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;
    logic signed_op;
    assign signed_op = (op == OP_MUL) || (op == OP_DIV);
    assign mul_op    = (op == OP_MULU) || (op == OP_MUL);
    assign div_op    = (op == OP_DIVU) || (op == OP_DIV);
    // Iterate on magnitudes; signs are re-applied when the last bit is done.
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
    assign neg_q_in  = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
    assign neg_r_in  = signed_op && a[WIDTH-1];
`else
    assign mul_op    = (op == OP_MULU);
    assign div_op    = (op == OP_DIVU);
    assign a_mag     = a;
    assign b_mag     = b;
    assign neg_q_in  = 1'b0;
    assign neg_r_in  = 1'b0;
`endif

    assign go_exec = mul_op || (div_op && (b != '0));

    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_dbz = 1'b0;
        sc_ill = 1'b0;
        case (op)
            OP_ADD:  sc_res = a + b;
            OP_SUB:  sc_res = a - b;
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_SLL:  sc_res = a << shamt;
            OP_SRL:  sc_res = a >> shamt;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MULU: sc_res = '0;
`ifdef BUBBLE_ALU_SIGNED_MD_EN
            OP_MUL:  sc_res = '0;
            OP_DIVU, OP_DIV: begin
`else
            OP_DIVU: begin
`endif
                // Only reached as a result when b==0; non-zero divisors iterate.
                sc_res = '1;
                sc_hi  = a;
                sc_dbz = 1'b1;
            end
            default: sc_ill = 1'b1;
        endcase
    end

    // One shift-add (mul) or one restoring-subtract (div) step per cycle.
    always_comb begin
        mul_add   = lo[0] ? ({1'b0, hi} + {1'b0, mcand}) : {1'b0, hi};
        div_shift = {hi, lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand};
        if (is_div_q) begin
            hi_n = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            hi_n = mul_add[WIDTH:1];
            lo_n = {mul_add[0], lo[WIDTH-1:1]};
        end
        prod_fix = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE: if (accept) state_nxt = go_exec ? EXEC : DONE;
            EXEC: if (last_iter) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result      <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            mcand       <= '0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else if (state == IDLE && accept) begin
            if (go_exec) begin
                cnt      <= '0;
                hi       <= '0;
                lo       <= div_op ? a_mag : b_mag;
                mcand    <= div_op ? b_mag : a_mag;
                is_div_q <= div_op;
                neg_q    <= neg_q_in;
                neg_r    <= neg_r_in && div_op;
            end else begin
                result      <= sc_res;
                result_hi   <= sc_hi;
                div_by_zero <= sc_dbz;
                illegal_op  <= sc_ill;
            end
        end else if (state == EXEC) begin
            cnt <= cnt + 1'b1;
            hi  <= hi_n;
            lo  <= lo_n;
            if (last_iter) begin
                div_by_zero <= 1'b0;
                illegal_op  <= 1'b0;
                if (is_div_q) begin
                    result    <= neg_q ? -lo_n : lo_n;
                    result_hi <= neg_r ? -hi_n : hi_n;
                end else begin
                    result    <= prod_fix[WIDTH-1:0];
                    result_hi <= prod_fix[2*WIDTH-1:WIDTH];
                end
            end
        end
    end
endmodule
